// File: rtl/adc128s_pkg.sv
// Shared constants and types for the ADC128S functional model.
package adc128s_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int ADDR_MSB   = 13;
    localparam int ADDR_LSB   = 11;
    localparam int ADDR_BITS  = ADDR_MSB - ADDR_LSB + 1;
    localparam int CNT_BITS   = $clog2(FRAME_BITS + 1);

    localparam logic [ADDR_BITS-1:0] CH_LFT_DEF   = 3'd0;
    localparam logic [ADDR_BITS-1:0] CH_RGHT_DEF  = 3'd4;
    localparam logic [ADDR_BITS-1:0] CH_STEER_DEF = 3'd5;
    localparam logic [ADDR_BITS-1:0] CH_BATT_DEF  = 3'd6;

    typedef logic [ADDR_BITS-1:0] ch_addr_t;
    typedef logic [DATA_BITS-1:0] sample_t;

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI mode-0 slave datapath: pin synchronizers, edge detection, bit counter,
// tx/rx shift registers. Reports frame end and whether it was exactly 16 bits.
module adc_spi_shifter
    import adc128s_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     SS_n,
    input  logic     SCLK,
    input  logic     MOSI,
    input  sample_t  sample,
    output logic     MISO,
    output logic     ss_rise,
    output logic     frame_ok,
    output ch_addr_t rx_addr
);

    logic [2:0]              ss_sync_reg;
    logic [2:0]              sclk_sync_reg;
    logic [1:0]              mosi_sync_reg;
    logic [FRAME_BITS-1:0]   tx_reg;
    // Only the low 14 received bits are kept; the address field is the top of this window.
    logic [ADDR_MSB:0]       rx_reg;
    logic [CNT_BITS-1:0]     cnt_reg;
    logic                    ovf_reg;

    logic ss_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic active;

    assign ss_fall   = ~ss_sync_reg[1] &  ss_sync_reg[2];
    assign ss_rise   =  ss_sync_reg[1] & ~ss_sync_reg[2];
    assign sclk_rise =  sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign sclk_fall = ~sclk_sync_reg[1] &  sclk_sync_reg[2];
    assign active    = ~ss_sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_reg   <= 3'b111;
            sclk_sync_reg <= 3'b000;
            mosi_sync_reg <= 2'b00;
            tx_reg        <= '0;
            rx_reg        <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[1:0], SS_n};
            sclk_sync_reg <= {sclk_sync_reg[1:0], SCLK};
            mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
            // Load wins over a coincident SCLK edge, which is dropped.
            if (ss_fall) begin
                tx_reg  <= {{(FRAME_BITS-DATA_BITS){1'b0}}, sample};
                cnt_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (active) begin
                if (sclk_rise) begin
                    if (cnt_reg == CNT_BITS'(FRAME_BITS)) begin
                        ovf_reg <= 1'b1;
                    end else begin
                        rx_reg  <= {rx_reg[ADDR_MSB-1:0], mosi_sync_reg[1]};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign MISO     = ~ss_sync_reg[2] & tx_reg[FRAME_BITS-1];
    assign frame_ok = (cnt_reg == CNT_BITS'(FRAME_BITS)) & ~ovf_reg;
    assign rx_addr  = rx_reg[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/adc128s_fc_model.sv
// Behavioural ADC128S slave: channel pointer and channel mux around the SPI shifter.
// Define ADC128S_FRAME_ERR_EN to add the frame_err pulse output.
module adc128s_fc_model
    import adc128s_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = CH_LFT_DEF,
    parameter logic [2:0] CH_RGHT  = CH_RGHT_DEF,
    parameter logic [2:0] CH_STEER = CH_STEER_DEF,
    parameter logic [2:0] CH_BATT  = CH_BATT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
`ifdef ADC128S_FRAME_ERR_EN
    output logic        frame_err,
`endif
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);

    ch_addr_t ptr_reg;
    sample_t  sample;
    ch_addr_t rx_addr;
    logic     ss_rise;
    logic     frame_ok;

    always_comb begin
        sample = '0;
        if (ptr_reg == CH_LFT)        sample = ld_cell_lft;
        else if (ptr_reg == CH_RGHT)  sample = ld_cell_rght;
        else if (ptr_reg == CH_STEER) sample = steerPot;
        else if (ptr_reg == CH_BATT)  sample = batt;
    end

    adc_spi_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .sample   (sample),
        .MISO     (MISO),
        .ss_rise  (ss_rise),
        .frame_ok (frame_ok),
        .rx_addr  (rx_addr)
    );

    // Only a clean 16-bit frame may retarget the next conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 3'd0;
        end else if (ss_rise && frame_ok) begin
            ptr_reg <= rx_addr;
        end
    end

`ifdef ADC128S_FRAME_ERR_EN
    logic frame_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= ss_rise & ~frame_ok;
        end
    end

    assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_adc128s_fc_model.sv
// Self-checking bench for adc128s_fc_model: SPI master tasks with a scoreboard queue.
module tb_adc128s_fc_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] ld_cell_lft  = 12'h000;
    logic [11:0] ld_cell_rght = 12'h000;
    logic [11:0] steerPot     = 12'h000;
    logic [11:0] batt         = 12'h000;
`ifdef ADC128S_FRAME_ERR_EN
    logic        frame_err;
    int          ferr_cnt = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    adc128s_fc_model dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
`ifdef ADC128S_FRAME_ERR_EN
        .frame_err    (frame_err),
`endif
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt)
    );

`ifdef ADC128S_FRAME_ERR_EN
    always @(posedge clk) if (frame_err === 1'b1) ferr_cnt++;
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    // Master side of one frame; rst_at >= 0 aborts the frame with a reset at that bit.
    task automatic spi_frame(input logic [15:0] word, input int nbits, input int rst_at,
                             output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst  = 1'b1;
                SS_n = 1'b1;
                SCLK = 1'b0;
                MOSI = 1'b0;
                repeat (4) @(negedge clk);
                rst = 1'b0;
                repeat (8) @(negedge clk);
                return;
            end
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            rx = {rx[14:0], MISO};
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (8) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] rx;
        logic [15:0] exp;
        ld_cell_lft  = 12'h123;
        ld_cell_rght = 12'h1F0;
        steerPot     = 12'h800;
        batt         = 12'hFFF;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b required 0", MISO);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_miso: got %b required 0", MISO);
        end
        exp_q.push_back(16'h0123);
        spi_frame(16'h2000, 16, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL first_frame: got %h required %h", rx, exp);
        end
        $display("frame mosi=2000 miso=%h", rx);
    endtask

    task automatic test_channels;
        logic [15:0] words[5];
        logic [15:0] exps[5];
        logic [15:0] rx;
        logic [15:0] exp;
        words = '{16'h2800, 16'h3000, 16'h3800, 16'h0000, 16'h2000};
        exps  = '{16'h01F0, 16'h0800, 16'h0FFF, 16'h0000, 16'h0123};
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(exps[k]);
            spi_frame(words[k], 16, -1, rx);
            exp = exp_q.pop_front();
            checks++;
            if (rx !== exp) begin
                errors++;
                $display("FAIL channel_%0d: got %h required %h", k, rx, exp);
            end
            checks++;
            if (MISO !== 1'b0) begin
                errors++;
                $display("FAIL idle_miso_%0d: got %b required 0", k, MISO);
            end
            $display("frame mosi=%h miso=%h", words[k], rx);
        end
    endtask

    task automatic test_frame_len;
        logic [15:0] rx;
        logic [15:0] exp;
        // pointer is 4 here; an 8-bit frame shows the top byte of 0x01F0
        exp_q.push_back(16'h0001);
        spi_frame(16'h3000, 8, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL short_frame: got %h required %h", rx, exp);
        end
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL short_idle_miso: got %b required 0", MISO);
        end
        $display("short frame mosi=3000 bits=8 miso=%h", rx);
        // 17 clocks: the first bit falls off, the extra bit reads 0
        exp_q.push_back(16'h03E0);
        spi_frame(16'h3000, 17, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL long_frame: got %h required %h", rx, exp);
        end
        $display("long frame mosi=3000 bits=17 miso=%h", rx);
        exp_q.push_back(16'h01F0);
        spi_frame(16'h3000, 16, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL ptr_unchanged: got %h required %h", rx, exp);
        end
        $display("frame mosi=3000 miso=%h", rx);
`ifdef ADC128S_FRAME_ERR_EN
        checks++;
        if (ferr_cnt !== 2) begin
            errors++;
            $display("FAIL frame_err_count: got %0d required 2", ferr_cnt);
        end
`endif
    endtask

    task automatic test_input_change;
        logic [15:0] rx;
        logic [15:0] exp;
        batt = 12'h100;
        exp_q.push_back(16'h0100);
        fork
            spi_frame(16'h3000, 16, -1, rx);
            begin
                repeat (60) @(negedge clk);
                batt = 12'h200;
            end
        join
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL batt_in_flight: got %h required %h", rx, exp);
        end
        $display("frame mosi=3000 miso=%h", rx);
        exp_q.push_back(16'h0200);
        spi_frame(16'h2800, 16, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL batt_next: got %h required %h", rx, exp);
        end
        $display("frame mosi=2800 miso=%h", rx);
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] rx;
        logic [15:0] exp;
        // pointer is 5 here; reset at bit 9 must return it to channel 0
        spi_frame(16'h2800, 16, 9, rx);
        $display("aborted frame mosi=2800 at bit 9");
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL abort_miso: got %b required 0", MISO);
        end
        exp_q.push_back(16'h0123);
        spi_frame(16'h0000, 16, -1, rx);
        exp = exp_q.pop_front();
        checks++;
        if (rx !== exp) begin
            errors++;
            $display("FAIL after_abort: got %h required %h", rx, exp);
        end
        $display("frame mosi=0000 miso=%h", rx);
`ifdef ADC128S_FRAME_ERR_EN
        checks++;
        if (ferr_cnt !== 2) begin
            errors++;
            $display("FAIL frame_err_after_reset: got %0d required 2", ferr_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_channels();
        test_frame_len();
        test_input_change();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
